// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/block widths plus the pmem arbiter state and source enums.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } pmem_arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } pmem_arb_src_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// Optional PMEM_ARB_RR_EN: alternate grants on simultaneous requests (default: D always wins).
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W  = $bits(lc3b_word),
  parameter int BLOCK_W = $bits(lc3b_block)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pmem_read,
  input  logic [ADDR_W-1:0]  i_pmem_address,
  output logic [BLOCK_W-1:0] i_pmem_rdata,
  output logic               i_pmem_resp,
  input  logic               d_pmem_read,
  input  logic               d_pmem_write,
  input  logic [ADDR_W-1:0]  d_pmem_address,
  input  logic [BLOCK_W-1:0] d_pmem_wdata,
  output logic [BLOCK_W-1:0] d_pmem_rdata,
  output logic               d_pmem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BLOCK_W-1:0] pmem_wdata,
  input  logic [BLOCK_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  pmem_arb_state_t state;
  pmem_arb_src_t   last_grant;

  logic d_req;
  logic i_req;
  logic grant_d;

  assign d_req = d_pmem_read | d_pmem_write;
  assign i_req = i_pmem_read;

`ifdef PMEM_ARB_RR_EN
  // On a tie, hand the port to whichever side did not get it last time.
  assign grant_d = d_req & (~i_req | (last_grant == SRC_I));
`else
  assign grant_d = d_req;
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == SRC_D);
`endif

  // NOTE: every state register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      last_grant   <= SRC_I;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            pmem_write   <= d_pmem_write;
            pmem_read    <= ~d_pmem_write;
            last_grant   <= SRC_D;
          end else if (i_req) begin
            state        <= SERVE_I;
            pmem_address <= i_pmem_address;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            last_grant   <= SRC_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data fans out to both caches; only the granted side sees resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized
// two-cache / one-memory run checked against a transaction-level model.
module tb_pmem_arbiter;
  import lc3b_types::*;

  localparam int AW = 16;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [BW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [BW-1:0] d_pmem_wdata;
  logic [BW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b addr=%h", pmem_read, pmem_write,
               i_pmem_resp, d_pmem_resp, pmem_address);
    end
    cyc();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=00", {pmem_read, pmem_write});
    end
  endtask

  task automatic test_i_read();
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    cyc();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h1230}) begin
      bad++;
      $display("FAIL i_read_strobe got=%b%b addr=%h want=10 addr=1230", pmem_read, pmem_write, pmem_address);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if ({pmem_read, i_pmem_resp, d_pmem_resp} !== 3'b100) begin
        bad++;
        $display("FAIL i_read_wait got=%b want=100", {pmem_read, i_pmem_resp, d_pmem_resp});
      end
    end
    pmem_rdata = {16{8'hA5}};
    pmem_resp  = 1'b1;
    #1;
    total++;
    if ({i_pmem_resp, d_pmem_resp, i_pmem_rdata} !== {2'b10, {16{8'hA5}}}) begin
      bad++;
      $display("FAIL i_read_resp got=%b%b data=%h", i_pmem_resp, d_pmem_resp, i_pmem_rdata);
    end
    cyc();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp} !== 3'b000) begin
      bad++;
      $display("FAIL i_read_done got=%b want=000", {pmem_read, pmem_write, i_pmem_resp});
    end
    cyc();
  endtask

  task automatic test_d_write();
    do_reset();
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4560;
    d_pmem_wdata   = {4{32'hDEAD_BEEF}};
    cyc();
    d_pmem_wdata = '0;
    total++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {2'b01, 16'h4560, {4{32'hDEAD_BEEF}}}) begin
      bad++;
      $display("FAIL d_write_strobe got=%b%b addr=%h wdata=%h", pmem_read, pmem_write, pmem_address, pmem_wdata);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++;
      if ({pmem_read, pmem_write, pmem_wdata} !== {2'b01, {4{32'hDEAD_BEEF}}}) begin
        bad++;
        $display("FAIL d_write_hold got=%b%b wdata=%h", pmem_read, pmem_write, pmem_wdata);
      end
    end
    pmem_resp = 1'b1;
    #1;
    total++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin
      bad++;
      $display("FAIL d_write_resp got=%b want=01", {i_pmem_resp, d_pmem_resp});
    end
    cyc();
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    total++;
    if ({pmem_read, pmem_write, d_pmem_resp} !== 3'b000) begin
      bad++;
      $display("FAIL d_write_done got=%b want=000", {pmem_read, pmem_write, d_pmem_resp});
    end
    cyc();
  endtask

  // Serves whatever is currently strobed; `who` is 1 for I, 2 for D.
  task automatic finish_xfer(input int who, input string name);
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    pmem_resp  = 1'b1;
    #1;
    total++;
    if ({i_pmem_resp, d_pmem_resp} !== {who == 1, who == 2}) begin
      bad++;
      $display("FAIL %s_resp got=%b%b want=%b%b", name, i_pmem_resp, d_pmem_resp, who == 1, who == 2);
    end
  endtask

  task automatic test_tie();
    logic [AW-1:0] exp_addr;
    int            second;
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1111;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h2222;
    cyc();
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h2222}) begin
      bad++;
      $display("FAIL tie1_grant got=%b addr=%h want=1 addr=2222", pmem_read, pmem_address);
    end
    cyc();
    finish_xfer(2, "tie1");
    // D immediately issues another request, so the next IDLE sees a second tie.
    d_pmem_address = 16'h3333;
    cyc();
    pmem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        bad++;
        $display("FAIL tie_dead_cycle%0d got=%b%b want=00", k, pmem_read, pmem_write);
      end
      cyc();
    end
`ifdef PMEM_ARB_RR_EN
    second = 1;
`else
    second = 2;
`endif
    exp_addr = (second == 1) ? 16'h1111 : 16'h3333;
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, exp_addr}) begin
      bad++;
      $display("FAIL tie2_grant got=%b addr=%h want=1 addr=%h", pmem_read, pmem_address, exp_addr);
    end
    finish_xfer(second, "tie2");
    if (second == 1) i_pmem_read = 1'b0;
    else d_pmem_read = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    cyc();
    cyc();
    exp_addr = (second == 1) ? 16'h3333 : 16'h1111;
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, exp_addr}) begin
      bad++;
      $display("FAIL tie3_grant got=%b addr=%h want=1 addr=%h", pmem_read, pmem_address, exp_addr);
    end
    finish_xfer(3 - second, "tie3");
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_addr_change();
    do_reset();
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h0010;
    cyc();
    d_pmem_address = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({pmem_read, pmem_address} !== {1'b1, 16'h0010}) begin
        bad++;
        $display("FAIL addr_hold%0d got=%b addr=%h want=1 addr=0010", k, pmem_read, pmem_address);
      end
      cyc();
    end
    finish_xfer(2, "addr_change");
    d_pmem_read = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0ABC;
    cyc();
    cyc();
    cyc();
    rst       = 1'b1;
    pmem_resp = 1'b1;
    #1;
    total++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid got=%b want=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
    end
    pmem_resp = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    total++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0ABC}) begin
      bad++;
      $display("FAIL reset_mid_regrant got=%b addr=%h want=1 addr=0abc", pmem_read, pmem_address);
    end
    finish_xfer(1, "reset_mid");
    i_pmem_read = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_stray_resp();
    do_reset();
    pmem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
        bad++;
        $display("FAIL stray_resp%0d got=%b want=0000", k, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
      end
      cyc();
    end
    pmem_resp      = 1'b0;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h7777;
    d_pmem_wdata   = {8{16'h5A5A}};
    cyc();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b01, 16'h7777}) begin
      bad++;
      $display("FAIL stray_then_grant got=%b%b addr=%h want=01 addr=7777", pmem_read, pmem_write, pmem_address);
    end
    finish_xfer(2, "stray");
    d_pmem_write = 1'b0;
    cyc();
    pmem_resp = 1'b0;
    cyc();
  endtask

  // Two random caches and a random-latency memory. The model tracks which requests
  // are pending at each clock edge and predicts the winner of each new transfer.
  task automatic test_random();
    logic          i_busy, d_busy, d_rd_pin, d_wr_pin, exp_last_d, just_done;
    logic [AW-1:0] i_a, d_a;
    logic [BW-1:0] d_wd, rd;
    int            cur, win, cnt, i_wait, d_wait, served, op;
    i_busy = 0; d_busy = 0; d_rd_pin = 0; d_wr_pin = 0;
    exp_last_d = 0; just_done = 0;
    i_a = '0; d_a = '0; d_wd = '0;
    cur = 0; cnt = 0; i_wait = 0; d_wait = 0; served = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (cur == 0 && (pmem_read || pmem_write)) begin
        total++;
        if (just_done || !(i_busy || d_busy)) begin
          bad++;
          $display("FAIL rnd_spurious_grant cycle=%0d just_done=%b pending=%b%b", c, just_done, i_busy, d_busy);
        end
        if (i_busy && d_busy) begin
`ifdef PMEM_ARB_RR_EN
          win = exp_last_d ? 1 : 2;
`else
          win = 2;
`endif
        end else begin
          win = d_busy ? 2 : 1;
        end
        cur        = win;
        exp_last_d = (win == 2);
        cnt        = $urandom_range(0, 4);
      end
      if (cur == 1) begin
        total++;
        if ({pmem_read, pmem_write, pmem_address} !== {2'b10, i_a}) begin
          bad++;
          $display("FAIL rnd_i_xfer cycle=%0d got=%b%b addr=%h want=10 addr=%h", c, pmem_read, pmem_write, pmem_address, i_a);
        end
      end else if (cur == 2) begin
        total++;
        if ({pmem_read, pmem_write, pmem_address} !== {~d_wr_pin, d_wr_pin, d_a} ||
            (d_wr_pin && pmem_wdata !== d_wd)) begin
          bad++;
          $display("FAIL rnd_d_xfer cycle=%0d got=%b%b addr=%h want=%b%b addr=%h", c, pmem_read, pmem_write,
                   pmem_address, ~d_wr_pin, d_wr_pin, d_a);
        end
      end else begin
        total++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
          bad++;
          $display("FAIL rnd_idle_strobe cycle=%0d got=%b%b want=00", c, pmem_read, pmem_write);
        end
      end
      just_done = 0;
      rd         = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = rd;
      if (cur != 0) begin
        pmem_resp = (cnt == 0);
        if (cnt > 0) cnt--;
      end else begin
        pmem_resp = ($urandom_range(0, 7) == 0);
      end
      if (cur == 1) i_pmem_address = AW'($urandom);
      if (cur == 2) begin
        d_pmem_address = AW'($urandom);
        d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      total++;
      if ({i_pmem_resp, d_pmem_resp, i_pmem_rdata, d_pmem_rdata} !==
          {pmem_resp && cur == 1, pmem_resp && cur == 2, rd, rd}) begin
        bad++;
        $display("FAIL rnd_resp cycle=%0d got=%b%b want=%b%b", c, i_pmem_resp, d_pmem_resp,
                 pmem_resp && cur == 1, pmem_resp && cur == 2);
      end
      if (pmem_resp && cur != 0) begin
        served++;
        if (cur == 1) i_busy = 0;
        else d_busy = 0;
        cur       = 0;
        just_done = 1;
      end
      if (i_busy) i_wait++;
      if (d_busy) d_wait++;
      if (i_wait > 60 || d_wait > 60) begin
        total++;
        bad++;
        $display("FAIL rnd_timeout cycle=%0d i_wait=%0d d_wait=%0d", c, i_wait, d_wait);
        clear_inputs();
        return;
      end
      if (!i_busy && $urandom_range(0, 2) == 0) begin
        i_busy = 1;
        i_a    = AW'($urandom);
        i_wait = 0;
      end
      if (!d_busy && $urandom_range(0, 2) == 0) begin
        d_busy   = 1;
        op       = $urandom_range(0, 2);
        d_rd_pin = (op != 1);
        d_wr_pin = (op != 0);
        d_a      = AW'($urandom);
        d_wd     = {$urandom, $urandom, $urandom, $urandom};
        d_wait   = 0;
      end
      if (!i_busy) i_wait = 0;
      if (!d_busy) d_wait = 0;
      i_pmem_read  = i_busy;
      d_pmem_read  = d_busy & d_rd_pin;
      d_pmem_write = d_busy & d_wr_pin;
      if (cur != 1) i_pmem_address = i_a;
      if (cur != 2) begin
        d_pmem_address = d_a;
        d_pmem_wdata   = d_wd;
      end
    end
    total++;
    if (served < 100) begin
      bad++;
      $display("FAIL rnd_throughput got=%0d want>=100", served);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_tie();
    test_addr_change();
    test_reset_mid();
    test_stray_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
